serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
//==============================================================================
// Module      : serial_subtractor
// Description : Bit-serial LSB-first subtractor (a - b) built on one full-adder
//               cell. Optional signed-overflow output with SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             w_load;
  logic             w_last;
  logic             w_bit;
  logic             w_cout;
  logic             w_nb;
  logic [WIDTH-1:0] w_res_next;

  // Subtraction as a + ~b + 1: the +1 is the carry preset at load time.
  assign w_nb   = ~r_b[0];
  assign w_bit  = r_a[0] ^ w_nb ^ r_carry;
  assign w_cout = (r_a[0] & w_nb) | (r_carry & (r_a[0] ^ w_nb));
  assign w_last = (r_cnt == C_LAST);

  generate
    if (WIDTH > 1) begin : g_res_wide
      assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
    end else begin : g_res_one
      assign w_res_next = w_bit;
    end
  endgenerate

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    out_busy     = 1'b0;
    out_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_start) begin
          w_state_next = S_SHIFT;
          w_load       = 1'b1;
        end
      end
      S_SHIFT: begin
        out_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_done = 1'b1;
        if (in_start) begin
          w_state_next = S_SHIFT;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result outputs load only on the final shift edge, so partial bits never show.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b1;
      out_diff   <= '0;
      out_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      out_ovf    <= 1'b0;
`endif
    end else if (w_load) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_cnt   <= '0;
      r_carry <= 1'b1;
    end else if (r_state == S_SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        out_diff   <= w_res_next;
        out_borrow <= ~w_cout;
`ifdef SERIAL_SUB_OVF_EN
        out_ovf    <= r_carry ^ w_cout;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//==============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor (WIDTH=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .in_clk     (clk),
    .in_rst     (rst),
    .in_start   (start),
    .in_a       (a),
    .in_b       (b),
    .out_busy   (busy),
    .out_done   (done),
    .out_diff   (diff),
    .out_borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .out_ovf    (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=diff 0x%0h expected=no pulse", diff);
      end else begin
        e = q.pop_front();
        chk("sb_diff", 32'(diff), 32'(e.diff));
        chk("sb_borrow", 32'(borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
        chk("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  function automatic exp_t mk(input logic [WIDTH-1:0] d, input logic br, input logic ov);
    exp_t e;
    e.diff   = d;
    e.borrow = br;
    e.ovf    = ov;
    return e;
  endfunction

  // Counts rising edges from just after the accepting edge until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL timeout_done actual=no pulse expected=pulse");
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input exp_t e);
    int n;
    start = 1'b1;
    a     = va;
    b     = vb;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(n);
    chk("latency", 32'(n), 32'(WIDTH));
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'h05, 8'h03, mk(8'h02, 1'b0, 1'b0));
    run_op(8'h03, 8'h05, mk(8'hFE, 1'b1, 1'b0));
    run_op(8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b1));
    run_op(8'h3C, 8'h00, mk(8'h3C, 1'b0, 1'b0));
    run_op(8'hA5, 8'hA5, mk(8'h00, 1'b0, 1'b0));

    // Mid-SHIFT start ignored, then held through DONE for a back-to-back op.
    q.push_back(mk(8'h0F, 1'b0, 1'b0));
    q.push_back(mk(8'h00, 1'b0, 1'b0));
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'hFF;
    repeat (WIDTH) @(posedge clk);
    #1;
    chk("b2b_done_first", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    chk("b2b_no_idle", 32'(busy), 32'd1);
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'(WIDTH));
    @(posedge clk);
    #1;

    run_op(8'h33, 8'h11, mk(8'h22, 1'b0, 1'b0));

    // Abort at SHIFT cycle 4 with an asynchronous reset.
    start = 1'b1;
    a     = 8'h55;
    b     = 8'h11;
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;

    run_op(8'h09, 8'h04, mk(8'h05, 1'b0, 1'b0));
    chk("hold_diff", 32'(diff), 32'h05);

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
